// File: rtl/hack_boot_pkg.sv
// Shared types for the HACK boot loader: FSM states, error codes and
// small state-classification helpers.
package hack_boot_pkg;

    typedef enum logic [3:0] {
        S_LEN_HI  = 4'd0,
        S_LEN_LO  = 4'd1,
        S_DATA_HI = 4'd2,
        S_DATA_LO = 4'd3,
        S_WRITE   = 4'd4,
        S_CSUM_HI = 4'd5,
        S_CSUM_LO = 4'd6,
        S_CHECK   = 4'd7,
        S_RUN     = 4'd8,
        S_ERROR   = 4'd9
    } state_e;

    typedef logic [1:0] err_code_t;

    localparam err_code_t ERR_NONE    = 2'd0;
    localparam err_code_t ERR_LEN     = 2'd1;
    localparam err_code_t ERR_CSUM    = 2'd2;
    localparam err_code_t ERR_TIMEOUT = 2'd3;

    // States in which the loader is willing to take a byte from the stream.
    function automatic logic is_byte_state(input state_e s);
        return s inside {S_LEN_HI, S_LEN_LO, S_DATA_HI, S_DATA_LO, S_CSUM_HI, S_CSUM_LO};
    endfunction

    // Byte states after the first frame byte: only these are bounded by the idle timer.
    function automatic logic is_timed_state(input state_e s);
        return s inside {S_LEN_LO, S_DATA_HI, S_DATA_LO, S_CSUM_HI, S_CSUM_LO};
    endfunction

endpackage

// File: rtl/hack_boot_loader_if.sv
// Byte-stream input and inst_mem write port of the boot loader.
// slave = the loader, master = the byte source / memory side.
interface hack_boot_loader_if;

    logic        rx_valid;
    logic [7:0]  rx_byte;
    logic        rx_ready;
    logic        im_we;
    logic [15:0] im_addr;
    logic [15:0] im_wdata;

    modport slave (
        input  rx_valid,
        input  rx_byte,
        output rx_ready,
        output im_we,
        output im_addr,
        output im_wdata
    );

    modport master (
        output rx_valid,
        output rx_byte,
        input  rx_ready,
        input  im_we,
        input  im_addr,
        input  im_wdata
    );

endinterface

// File: rtl/hack_boot_timer.sv
// Inter-byte idle timer. Down-counter reloaded on clear; expired is raised
// during the TIMEOUT-th consecutive enabled cycle without a clear, so the
// caller can leave on that same clock edge.
module hack_boot_timer #(
    parameter int TIMEOUT = 1000000
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [W-1:0] RELOAD = W'(TIMEOUT - 1);

    logic [W-1:0] count_q;

    // Count idle cycles down towards the terminal count, holding at zero.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q <= RELOAD;
        end else if (clear) begin
            count_q <= RELOAD;
        end else if (enable && (count_q != '0)) begin
            count_q <= count_q - W'(1);
        end
    end

    assign expired = enable && (count_q == '0);

endmodule

// File: rtl/hack_boot_loader.sv
// HACK program loader: holds the CPU in reset, receives a length-prefixed,
// checksummed big-endian word stream, writes it into inst_mem and releases
// the CPU on a good checksum.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// LEN_HI    | waiting for length high byte (no timeout)
// LEN_LO    | waiting for length low byte; length range check
// DATA_HI   | waiting for high byte of next word
// DATA_LO   | waiting for low byte of next word
// WRITE     | one-cycle inst_mem write of the assembled word
// CSUM_HI   | waiting for checksum high byte
// CSUM_LO   | waiting for checksum low byte
// CHECK     | compare running sum against received checksum
// RUN       | program loaded, CPU released
// ERROR     | load failed, err_code valid, CPU held in reset
module hack_boot_loader
    import hack_boot_pkg::*;
#(
    parameter int ADDR_W  = 15,
    parameter int TIMEOUT = 1000000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_req,
    hack_boot_loader_if.slave bus,
    output logic              cpu_reset,
    output logic              done,
    output logic              err,
    output logic [1:0]        err_code
);

    // Largest legal length is a full memory; 17 bits so ADDR_W=16 still fits.
    localparam logic [16:0] MAX_LEN = 17'(1) << ADDR_W;

    state_e      state_q, state_d;
    err_code_t   err_code_q, err_code_d;
    logic        restart;

    logic        rx_ready_q;
    logic        im_we_q;
    logic [15:0] im_addr_q;
    logic [15:0] im_wdata_q;
    logic        cpu_reset_q;
    logic        done_q;
    logic        err_q;

    logic [7:0]  hi_q;
    logic [15:0] len_q;
    logic [15:0] csum_q;
    logic [15:0] sum_q;
    logic [16:0] index_q;

    logic        accept;
    logic [15:0] byte_pair;
    logic        last_word;
    logic        timer_en;
    logic        timer_clear;
    logic        idle_expired;

    assign accept      = bus.rx_valid && rx_ready_q;
    assign byte_pair   = {hi_q, bus.rx_byte};
    assign last_word   = (index_q + 17'd1) == {1'b0, len_q};
    assign timer_en    = is_timed_state(state_q);
    assign timer_clear = accept || !timer_en;

    hack_boot_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk     (clk),
        .reset   (reset),
        .clear   (timer_clear),
        .enable  (timer_en),
        .expired (idle_expired)
    );

    // Next-state and error-code decode; an accepted byte wins over the timer.
    always_comb begin
        state_d    = state_q;
        err_code_d = err_code_q;
        restart    = 1'b0;
        case (state_q)
            S_LEN_HI: begin
                if (accept) state_d = S_LEN_LO;
            end
            S_LEN_LO: begin
                if (accept) begin
                    if ({1'b0, byte_pair} > MAX_LEN) begin
                        state_d    = S_ERROR;
                        err_code_d = ERR_LEN;
                    end else if (byte_pair == 16'd0) begin
                        state_d = S_CSUM_HI;
                    end else begin
                        state_d = S_DATA_HI;
                    end
                end else if (idle_expired) begin
                    state_d    = S_ERROR;
                    err_code_d = ERR_TIMEOUT;
                end
            end
            S_DATA_HI, S_DATA_LO, S_CSUM_HI, S_CSUM_LO: begin
                if (accept) begin
                    case (state_q)
                        S_DATA_HI: state_d = S_DATA_LO;
                        S_DATA_LO: state_d = S_WRITE;
                        S_CSUM_HI: state_d = S_CSUM_LO;
                        default:   state_d = S_CHECK;
                    endcase
                end else if (idle_expired) begin
                    state_d    = S_ERROR;
                    err_code_d = ERR_TIMEOUT;
                end
            end
            S_WRITE: begin
                state_d = last_word ? S_CSUM_HI : S_DATA_HI;
            end
            S_CHECK: begin
                if (sum_q == csum_q) begin
                    state_d = S_RUN;
                end else begin
                    state_d    = S_ERROR;
                    err_code_d = ERR_CSUM;
                end
            end
            S_RUN: begin
                if (load_req) begin
                    state_d = S_LEN_HI;
                    restart = 1'b1;
                end
            end
            S_ERROR: begin
                if (load_req) begin
                    state_d    = S_LEN_HI;
                    err_code_d = ERR_NONE;
                    restart    = 1'b1;
                end
            end
            default: state_d = S_LEN_HI;
        endcase
    end

    // State register plus outputs registered from the next state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_LEN_HI;
            err_code_q  <= ERR_NONE;
            rx_ready_q  <= 1'b0;
            im_we_q     <= 1'b0;
            cpu_reset_q <= 1'b1;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            err_code_q  <= err_code_d;
            rx_ready_q  <= is_byte_state(state_d);
            im_we_q     <= (state_d == S_WRITE);
            cpu_reset_q <= (state_d != S_RUN);
            done_q      <= (state_d == S_RUN);
            err_q       <= (state_d == S_ERROR);
        end
    end

    // Byte capture, word assembly, write address/data, checksum and word index.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hi_q       <= 8'd0;
            len_q      <= 16'd0;
            csum_q     <= 16'd0;
            sum_q      <= 16'd0;
            index_q    <= 17'd0;
            im_addr_q  <= 16'd0;
            im_wdata_q <= 16'd0;
        end else if (restart) begin
            sum_q   <= 16'd0;
            index_q <= 17'd0;
        end else begin
            if (accept) begin
                case (state_q)
                    S_LEN_HI, S_DATA_HI, S_CSUM_HI: hi_q <= bus.rx_byte;
                    S_LEN_LO:  len_q <= byte_pair;
                    S_DATA_LO: begin
                        im_addr_q  <= index_q[15:0];
                        im_wdata_q <= byte_pair;
                        sum_q      <= sum_q + byte_pair;
                    end
                    S_CSUM_LO: csum_q <= byte_pair;
                    default: ;
                endcase
            end
            if (state_q == S_WRITE) index_q <= index_q + 17'd1;
        end
    end

    assign bus.rx_ready = rx_ready_q;
    assign bus.im_we    = im_we_q;
    assign bus.im_addr  = im_addr_q;
    assign bus.im_wdata = im_wdata_q;
    assign cpu_reset    = cpu_reset_q;
    assign done         = done_q;
    assign err          = err_q;
    assign err_code     = err_code_q;

endmodule

// File: tb/tb_hack_boot_loader.sv
// Bench for hack_boot_loader (ADDR_W=4, TIMEOUT=16): directed frames, a
// byte-position reference model checked every cycle, and literal checks.
module tb_hack_boot_loader;

    localparam int ADDR_W  = 4;
    localparam int TIMEOUT = 16;

    typedef logic [7:0] byteq_t[$];

    logic       clk;
    logic       reset;
    logic       load_req;
    logic       cpu_reset, done, err;
    logic [1:0] err_code;

    hack_boot_loader_if bus();

    hack_boot_loader #(
        .ADDR_W  (ADDR_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .load_req  (load_req),
        .bus       (bus),
        .cpu_reset (cpu_reset),
        .done      (done),
        .err       (err),
        .err_code  (err_code)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;
    int cyc   = 0;

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            if (n_bad <= 40)
                $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: tracks the frame by count of accepted bytes.
    int          m_phase;      // 0 loading, 1 running, 2 failed
    int          m_nbytes;
    int          m_len;
    int          m_idle;
    int          m_n;
    bit          m_wr_gap, m_ck_gap, m_acc;
    logic [7:0]  m_hi;
    logic [15:0] m_sum, m_csum;
    logic        e_ready, e_we, e_cpu_reset, e_done, e_err;
    logic [15:0] e_addr, e_wdata;
    logic [1:0]  e_code;

    task automatic m_fail(input logic [1:0] c);
        m_phase  = 2;
        e_code   = c;
        m_wr_gap = 0;
        m_ck_gap = 0;
    endtask

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_phase = 0; m_nbytes = 0; m_len = 0; m_idle = 0;
            m_wr_gap = 0; m_ck_gap = 0; m_hi = 0; m_sum = 0; m_csum = 0;
            e_ready = 0; e_we = 0; e_cpu_reset = 1; e_done = 0; e_err = 0;
            e_addr = 0; e_wdata = 0; e_code = 0;
        end else begin
            m_acc = bus.rx_valid && e_ready;
            e_we  = 0;
            if (m_phase != 0) begin
                if (load_req) begin
                    if (m_phase == 2) e_code = 0;
                    m_phase = 0; m_nbytes = 0; m_idle = 0; m_sum = 0;
                end
            end else if (m_wr_gap) begin
                m_wr_gap = 0;
            end else if (m_ck_gap) begin
                m_ck_gap = 0;
                if (m_sum == m_csum) m_phase = 1;
                else m_fail(2'd2);
            end else if (m_acc) begin
                m_idle = 0;
                m_n = m_nbytes;
                m_nbytes++;
                if (m_n == 0) begin
                    m_hi = bus.rx_byte;
                end else if (m_n == 1) begin
                    m_len = int'({m_hi, bus.rx_byte});
                    if (m_len > (1 << ADDR_W)) m_fail(2'd1);
                end else if (m_n < 2 + 2 * m_len) begin
                    if ((m_n % 2) == 0) begin
                        m_hi = bus.rx_byte;
                    end else begin
                        e_we     = 1;
                        e_addr   = 16'((m_n - 3) / 2);
                        e_wdata  = {m_hi, bus.rx_byte};
                        m_sum    = m_sum + {m_hi, bus.rx_byte};
                        m_wr_gap = 1;
                    end
                end else if (m_n == 2 + 2 * m_len) begin
                    m_hi = bus.rx_byte;
                end else begin
                    m_csum   = {m_hi, bus.rx_byte};
                    m_ck_gap = 1;
                end
            end else if (m_nbytes > 0) begin
                m_idle++;
                if (m_idle == TIMEOUT) m_fail(2'd3);
            end
            e_ready     = (m_phase == 0) && !m_wr_gap && !m_ck_gap;
            e_cpu_reset = (m_phase != 1);
            e_done      = (m_phase == 1);
            e_err       = (m_phase == 2);
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        chk("rx_ready",  bus.rx_ready, e_ready);
        chk("im_we",     bus.im_we,    e_we);
        chk("im_addr",   bus.im_addr,  e_addr);
        chk("im_wdata",  bus.im_wdata, e_wdata);
        chk("cpu_reset", cpu_reset,    e_cpu_reset);
        chk("done",      done,         e_done);
        chk("err",       err,          e_err);
        chk("err_code",  err_code,     e_code);
    end

    // Shadow of inst_mem built from the DUT write port.
    logic [15:0] mem [0:15];
    int          we_count = 0;

    always @(negedge clk) begin
        if (bus.im_we === 1'b1) begin
            mem[bus.im_addr[3:0]] = bus.im_wdata;
            we_count++;
        end
    end

    task automatic send_byte(input logic [7:0] b, input int gap);
        int guard;
        if (gap > 0) begin
            bus.rx_valid = 1'b0;
            repeat (gap) @(posedge clk);
            #1;
        end
        bus.rx_valid = 1'b1;
        bus.rx_byte  = b;
        guard = 0;
        @(negedge clk);
        while (bus.rx_ready !== 1'b1 && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        chk("accept_wait", bus.rx_ready, 1);
        @(posedge clk);
        #1;
    endtask

    task automatic send_seq(input byteq_t q, input int max_gap);
        foreach (q[i]) send_byte(q[i], (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0);
        bus.rx_valid = 1'b0;
    endtask

    function automatic byteq_t make_frame(input logic [15:0] w[$]);
        byteq_t      q;
        logic [15:0] s;
        logic [15:0] n;
        s = 16'd0;
        n = 16'(w.size());
        q.push_back(n[15:8]);
        q.push_back(n[7:0]);
        foreach (w[i]) begin
            q.push_back(w[i][15:8]);
            q.push_back(w[i][7:0]);
            s = s + w[i];
        end
        q.push_back(s[15:8]);
        q.push_back(s[7:0]);
        return q;
    endfunction

    task automatic pulse_load_req();
        load_req = 1'b1;
        @(posedge clk);
        #1;
        load_req = 1'b0;
    endtask

    byteq_t      good, bad, zero, ovf, part;
    logic [15:0] words[$];
    int          we0;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, %0d vectors", n_vec);
        $fatal(1, "watchdog");
    end

    initial begin
        good = '{8'h00, 8'h03, 8'h00, 8'h10, 8'hEC, 8'h10, 8'h00, 8'h03, 8'hEC, 8'h23};
        bad  = '{8'h00, 8'h03, 8'h00, 8'h10, 8'hEC, 8'h10, 8'h00, 8'h03, 8'hEC, 8'h24};
        zero = '{8'h00, 8'h00, 8'h00, 8'h00};
        ovf  = '{8'h00, 8'h11};
        part = '{8'h00, 8'h03, 8'h00};

        reset = 1'b0; load_req = 1'b0;
        bus.rx_valid = 1'b0; bus.rx_byte = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_cpu_reset", cpu_reset, 1);
        chk("rst_rx_ready", bus.rx_ready, 0);
        chk("rst_done", done, 0);
        reset = 1'b1;
        @(posedge clk); #1;
        chk("ready_after_release", bus.rx_ready, 1);

        // Good load, valid held high.
        we0 = we_count;
        send_seq(good, 0);
        chk("good_cpu_reset_t1", cpu_reset, 1);
        @(posedge clk); #1;
        chk("good_cpu_reset_t2", cpu_reset, 0);
        chk("good_done", done, 1);
        chk("good_we_count", we_count - we0, 3);
        chk("good_mem0", mem[0], 16'h0010);
        chk("good_mem1", mem[1], 16'hEC10);
        chk("good_mem2", mem[2], 16'h0003);

        // load_req from RUN, then a bad checksum.
        pulse_load_req();
        chk("reload_cpu_reset", cpu_reset, 1);
        chk("reload_done", done, 0);
        send_seq(bad, 0);
        @(posedge clk); #1;
        chk("csum_err", err, 1);
        chk("csum_code", err_code, 2);
        chk("csum_cpu_reset", cpu_reset, 1);
        pulse_load_req();
        chk("recover_err", err, 0);
        send_seq(good, 0);
        @(posedge clk); #1;
        chk("recover_done", done, 1);

        // Zero length.
        pulse_load_req();
        we0 = we_count;
        send_seq(zero, 0);
        @(posedge clk); #1;
        chk("zero_done", done, 1);
        chk("zero_we_count", we_count - we0, 0);

        // Length overflow: 17 words into a 16-word memory.
        pulse_load_req();
        send_seq(ovf, 0);
        chk("ovf_err", err, 1);
        chk("ovf_code", err_code, 1);
        chk("ovf_ready", bus.rx_ready, 0);

        // Inter-byte timeout.
        pulse_load_req();
        send_seq(part, 0);
        repeat (TIMEOUT - 1) @(posedge clk);
        #1;
        chk("timeout_not_yet", err, 0);
        @(posedge clk); #1;
        chk("timeout_err", err, 1);
        chk("timeout_code", err_code, 3);

        // Idle in LEN_HI never times out.
        pulse_load_req();
        repeat (1000) @(posedge clk);
        #1;
        chk("len_hi_idle_err", err, 0);
        chk("len_hi_idle_ready", bus.rx_ready, 1);

        // Full-memory frame with random gaps.
        words.delete();
        for (int i = 0; i < 16; i++) words.push_back(16'($urandom));
        we0 = we_count;
        send_seq(make_frame(words), 3);
        @(posedge clk); #1;
        chk("full_done", done, 1);
        chk("full_we_count", we_count - we0, 16);
        for (int i = 0; i < 16; i++) chk("full_mem", mem[i], words[i]);

        // Backpressure with random gaps on a short frame.
        pulse_load_req();
        words.delete();
        for (int i = 0; i < 5; i++) words.push_back(16'($urandom));
        send_seq(make_frame(words), 6);
        @(posedge clk); #1;
        chk("bp_done", done, 1);
        for (int i = 0; i < 5; i++) chk("bp_mem", mem[i], words[i]);

        // Reset mid-DATA.
        pulse_load_req();
        send_seq('{8'h00, 8'h02, 8'h12}, 0);
        bus.rx_valid = 1'b1;
        bus.rx_byte  = 8'h34;
        #2;
        reset = 1'b0;
        #1;
        chk("mid_rst_ready", bus.rx_ready, 0);
        chk("mid_rst_we", bus.im_we, 0);
        chk("mid_rst_addr", bus.im_addr, 0);
        chk("mid_rst_wdata", bus.im_wdata, 0);
        chk("mid_rst_cpu_reset", cpu_reset, 1);
        chk("mid_rst_err_code", err_code, 0);
        we0 = we_count;
        repeat (3) @(posedge clk);
        #1;
        chk("mid_rst_no_we", we_count - we0, 0);
        bus.rx_valid = 1'b0;
        reset = 1'b1;
        @(posedge clk); #1;
        send_seq(good, 0);
        @(posedge clk); #1;
        chk("after_rst_done", done, 1);
        chk("after_rst_mem1", mem[1], 16'hEC10);

        @(posedge clk); #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/hack_boot_loader.md
Name: hack_boot_loader

Overview:
Program-load controller for the HACK instruction memory. Holds the CPU in reset, receives a length-prefixed, checksummed program as a byte stream (valid/ready), and writes it word-by-word into inst_mem. On a good checksum it releases the CPU to run from PC=0. It sits between the top level's external byte source (UART RX/host) and the inst_mem write port plus CPU reset.

Parameters:
ADDR_W, 15, inst_mem address width; max program = 2^ADDR_W words.
TIMEOUT, 1000000, max idle cycles between bytes once a frame has started.

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
load_req  in  1  single-cycle pulse; restarts loading from RUN or ERROR
rx_valid  in  1  rx_byte valid
rx_byte  in  8  incoming byte
rx_ready  out  1  loader accepts byte; transfer = rx_valid & rx_ready
im_we  out  1  inst_mem write enable, one cycle per word
im_addr  out  16  write address, zero-extended word index
im_wdata  out  16  write data
cpu_reset  out  1  active-high reset to CPU
done  out  1  program loaded, CPU running
err  out  1  load failed
err_code  out  2  0 none, 1 LEN, 2 CSUM, 3 TIMEOUT

Behaviour:
- Frame: LEN_HI, LEN_LO, then LEN words as (HI, LO) byte pairs, then CSUM_HI, CSUM_LO. All big-endian. Checksum = 16-bit modular sum of the data words.
- States: LEN_HI, LEN_LO, DATA_HI, DATA_LO, WRITE, CSUM_HI, CSUM_LO, CHECK, RUN, ERROR.
- Reset (reset=0): state LEN_HI, cpu_reset=1, rx_ready=0, im_we=0, im_addr=0, im_wdata=0, done=0, err=0, err_code=0, sum=0, counters=0.
- rx_ready is registered. It is 1 in LEN_*, DATA_* and CSUM_* states from the first cycle after reset release, and 0 in WRITE, CHECK, RUN and ERROR. A byte held on rx_valid during a 0-ready cycle is not consumed.
- LEN_LO accept:
  - LEN > 2^ADDR_W: ERROR, err_code=1.
  - LEN = 0: CSUM_HI.
  - Otherwise: DATA_HI.
- DATA_LO accept at cycle t: WRITE at t+1, with im_we=1, im_addr=index, im_wdata={hi,lo}, and sum += word. At t+2: index+1, im_we=0, then DATA_HI, or CSUM_HI after the last word.
- CSUM_LO accept at t: CHECK at t+1. At t+2:
  - match: RUN, with cpu_reset=0 and done=1.
  - mismatch: ERROR, err_code=2.
- Timeout: the idle counter runs only in LEN_LO, DATA_*, CSUM_* (i.e. after the first frame byte) and clears on every accepted byte. When it reaches TIMEOUT: ERROR, err_code=3. LEN_HI waits forever.
- ERROR: cpu_reset=1, err=1, err_code held. Only load_req leaves it: next state LEN_HI, err cleared.
- RUN: load_req makes the next state LEN_HI, with cpu_reset=1 and done=0 that same next cycle, and index, sum and counter cleared. load_req in a load state is ignored.
- Reset mid-frame aborts immediately, with no further im_we. Partial inst_mem contents are undefined.
- im_we is never asserted outside WRITE. cpu_reset is 0 only in RUN.

Decomposition:
- hack_boot_pkg: state enum; err_code constants ERR_NONE/LEN/CSUM/TIMEOUT.
- Sub-module hack_boot_timer: idle counter with clear and enable inputs and an expired output, parameterised by TIMEOUT.
- FSM, word assembly and checksum stay in hack_boot_loader.

Test Plan:
- Good load: stream 00 03 00 10 EC 10 00 03 EC 23 with rx_valid held high -> writes addr0=0x0010, addr1=0xEC10, addr2=0x0003, each a single im_we cycle. cpu_reset falls 2 cycles after the last byte is accepted, done=1.
- Bad checksum: same frame ending EC 24 -> err=1, err_code=2, cpu_reset stays 1. Then load_req plus the good frame -> done=1.
- Zero length: 00 00 00 00 -> RUN with no im_we pulses.
- Length overflow (ADDR_W=4): 00 11 -> ERROR, err_code=1, on the cycle after the second byte; rx_ready=0 afterward.
- Timeout (TIMEOUT=16): 00 03 00, then rx_valid=0 for 16 cycles -> err_code=3. Also: rx_valid=0 for 1000 cycles in LEN_HI -> no error.
- Backpressure and reset: rx_valid toggling randomly still gives correct writes. A byte presented during WRITE is accepted only after. reset=0 mid-DATA -> all outputs at reset values, next frame loads cleanly. load_req in RUN -> cpu_reset=1 the next cycle.
